branch_predictor: RTL and testbench

Fetch-stage branch predictor: a direct-mapped branch target buffer with a 2-bit saturating direction counter per entry. It predicts taken/not-taken and the target for the fetch PC one cycle after lookup, in step with the instruction cache. The execute stage trains it with resolved outcomes, where `taken` is the branch-enable result of the execute-stage branch unit. It closes the loop between branch resolution in execute and PC selection in fetch.

---
 rtl/bp_pkg.sv | 22 ++
 rtl/branch_predictor_if.sv | 27 ++
 rtl/bp_sat_cnt.sv | 22 ++
 rtl/branch_predictor.sv | 96 +++++++++
 tb/tb_branch_predictor.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/bp_pkg.sv
// Shared types and constants for the fetch-stage branch predictor.
package bp_pkg;

   typedef enum logic [1:0] {
      CNT_SNT = 2'b00,
      CNT_WNT = 2'b01,
      CNT_WT  = 2'b10,
      CNT_ST  = 2'b11
   } cnt_e;

   localparam cnt_e CNT_ALLOC_BR  = CNT_WT;
   localparam cnt_e CNT_ALLOC_JMP = CNT_ST;

   function automatic int idx_w(input int entries);
      return $clog2(entries);
   endfunction

   function automatic int tag_w(input int entries);
      return 30 - $clog2(entries);
   endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch-lookup and execute-update signals of the branch predictor.
interface branch_predictor_if;
   logic        i_fetch_en;
   logic [31:0] i_pc;
   logic        i_stall;
   logic        i_flush;
   logic        o_pred_valid;
   logic        o_pred_taken;
   logic [31:0] o_pred_target;
   logic        i_upd_en;
   logic [31:0] i_upd_pc;
   logic [31:0] i_upd_target;
   logic        i_upd_taken;
   logic        i_upd_jump;

   modport slave (
      input  i_fetch_en, i_pc, i_stall, i_flush,
      input  i_upd_en, i_upd_pc, i_upd_target, i_upd_taken, i_upd_jump,
      output o_pred_valid, o_pred_taken, o_pred_target
   );

   modport master (
      output i_fetch_en, i_pc, i_stall, i_flush,
      output i_upd_en, i_upd_pc, i_upd_target, i_upd_taken, i_upd_jump,
      input  o_pred_valid, o_pred_taken, o_pred_target
   );
endinterface

// File: rtl/bp_sat_cnt.sv
// 2-bit saturating direction counter next-state; force_strong_i pins it at strongly taken.
module bp_sat_cnt
   import bp_pkg::*;
(
   input  logic [1:0] cnt_i,
   input  logic       taken_i,
   input  logic       force_strong_i,
   output logic [1:0] cnt_o
);

   always_comb begin
      cnt_o = cnt_i;
      if (force_strong_i) begin
         cnt_o = CNT_ST;
      end else if (taken_i) begin
         if (cnt_i != CNT_ST) cnt_o = cnt_i + 2'd1;
      end else begin
         if (cnt_i != CNT_SNT) cnt_o = cnt_i - 2'd1;
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry 2-bit direction counter; registered one-cycle lookup,
// trained by resolved control transfers from execute.
module branch_predictor
   import bp_pkg::*;
#(
   parameter int ENTRIES = 16
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   branch_predictor_if.slave  bp
);

   localparam int IDX_W = idx_w(ENTRIES);
   localparam int TAG_W = tag_w(ENTRIES);

   logic [ENTRIES-1:0] valid_q;
   logic [TAG_W-1:0]   tag_q [ENTRIES];
   logic [29:0]        tgt_q [ENTRIES];
   logic [1:0]         cnt_q [ENTRIES];

   logic        pred_valid_q, pred_valid_d;
   logic        pred_taken_q, pred_taken_d;
   logic [31:0] pred_target_q, pred_target_d;

   logic [IDX_W-1:0] f_idx, u_idx;
   logic [TAG_W-1:0] f_tag, u_tag;
   logic             f_hit, u_hit;
   logic [1:0]       sat_next, cnt_d;
   logic             cnt_we, entry_we;
   logic             unused_addr_bits;

   assign f_idx = bp.i_pc[IDX_W+1:2];
   assign f_tag = bp.i_pc[31:IDX_W+2];
   assign u_idx = bp.i_upd_pc[IDX_W+1:2];
   assign u_tag = bp.i_upd_pc[31:IDX_W+2];
   assign unused_addr_bits = ^{bp.i_pc[1:0], bp.i_upd_pc[1:0], bp.i_upd_target[1:0]};

   // Both lookups read the arrays as they stand before this edge's write.
   assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
   assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

   bp_sat_cnt u_sat_cnt (
      .cnt_i          (cnt_q[u_idx]),
      .taken_i        (bp.i_upd_taken),
      .force_strong_i (bp.i_upd_jump),
      .cnt_o          (sat_next)
   );

   assign cnt_we   = bp.i_upd_en && (u_hit || bp.i_upd_taken);
   assign entry_we = bp.i_upd_en && bp.i_upd_taken;
   assign cnt_d    = u_hit ? sat_next
                   : (bp.i_upd_jump ? CNT_ALLOC_JMP : CNT_ALLOC_BR);

   always_comb begin
      pred_valid_d  = pred_valid_q;
      pred_taken_d  = pred_taken_q;
      pred_target_d = pred_target_q;
      if (bp.i_flush) begin
         pred_valid_d  = 1'b0;
         pred_taken_d  = 1'b0;
         pred_target_d = '0;
      end else if (!bp.i_stall) begin
         pred_valid_d  = bp.i_fetch_en;
         pred_taken_d  = bp.i_fetch_en && f_hit && cnt_q[f_idx][1];
         pred_target_d = (bp.i_fetch_en && f_hit) ? {tgt_q[f_idx], 2'b00} : '0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         valid_q       <= '0;
         pred_valid_q  <= 1'b0;
         pred_taken_q  <= 1'b0;
         pred_target_q <= '0;
      end else begin
         if (entry_we) valid_q[u_idx] <= 1'b1;
         pred_valid_q  <= pred_valid_d;
         pred_taken_q  <= pred_taken_d;
         pred_target_q <= pred_target_d;
      end
   end

   // Payload arrays are only reachable through valid_q, so they carry no reset.
   always_ff @(posedge i_clk) begin
      if (cnt_we) cnt_q[u_idx] <= cnt_d;
      if (entry_we) begin
         tag_q[u_idx] <= u_tag;
         tgt_q[u_idx] <= bp.i_upd_target[31:2];
      end
   end

   assign bp.o_pred_valid  = pred_valid_q;
   assign bp.o_pred_taken  = pred_taken_q;
   assign bp.o_pred_target = pred_target_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: reset, training, aliasing, jumps, same-cycle
// read-before-write, stall/flush and asynchronous reset.
module tb_branch_predictor;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;
   logic [33:0] got;
   logic [33:0] exp;

   branch_predictor_if bp_if ();

   branch_predictor #(.ENTRIES(16)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bp      (bp_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [33:0] obs();
      return {bp_if.o_pred_valid, bp_if.o_pred_taken, bp_if.o_pred_target};
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic lookup(input logic [31:0] pc);
      bp_if.i_fetch_en = 1'b1;
      bp_if.i_pc       = pc;
      cyc();
      bp_if.i_fetch_en = 1'b0;
   endtask

   task automatic update(input logic [31:0] pc, input logic [31:0] tgt,
                         input logic taken, input logic jump);
      bp_if.i_upd_en     = 1'b1;
      bp_if.i_upd_pc     = pc;
      bp_if.i_upd_target = tgt;
      bp_if.i_upd_taken  = taken;
      bp_if.i_upd_jump   = jump;
      cyc();
      bp_if.i_upd_en     = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bp_if.i_fetch_en = 1'b0; bp_if.i_pc = '0; bp_if.i_stall = 1'b0; bp_if.i_flush = 1'b0;
      bp_if.i_upd_en = 1'b0; bp_if.i_upd_pc = '0; bp_if.i_upd_target = '0;
      bp_if.i_upd_taken = 1'b0; bp_if.i_upd_jump = 1'b0;
      cyc(); cyc();
      got = obs(); exp = '0; total++;
      if (got !== exp) begin bad++; $display("FAIL reset_outputs: got=%h want=%h", got, exp); end
      #2 rst_n = 1'b1;
      lookup(32'h100);
      got = obs(); exp = {1'b1, 1'b0, 32'h0}; total++;
      if (got !== exp) begin bad++; $display("FAIL reset_lookup_miss: got=%h want=%h", got, exp); end
      cyc();
      got = obs(); exp = '0; total++;
      if (got !== exp) begin bad++; $display("FAIL idle_no_valid: got=%h want=%h", got, exp); end
   endtask

   task automatic test_train();
      update(32'h100, 32'h40, 1'b1, 1'b0);
      lookup(32'h100);
      got = obs(); exp = {1'b1, 1'b1, 32'h40}; total++;
      if (got !== exp) begin bad++; $display("FAIL train_alloc_wt: got=%h want=%h", got, exp); end
      update(32'h100, 32'h0, 1'b0, 1'b0);
      lookup(32'h100);
      got = obs(); exp = {1'b1, 1'b0, 32'h40}; total++;
      if (got !== exp) begin bad++; $display("FAIL train_wnt: got=%h want=%h", got, exp); end
      update(32'h100, 32'h0, 1'b0, 1'b0);
      update(32'h100, 32'h0, 1'b0, 1'b0);
      update(32'h100, 32'h44, 1'b1, 1'b0);
      lookup(32'h100);
      got = obs(); exp = {1'b1, 1'b0, 32'h44}; total++;
      if (got !== exp) begin bad++; $display("FAIL train_snt_saturate: got=%h want=%h", got, exp); end
      update(32'h100, 32'h48, 1'b1, 1'b0);
      lookup(32'h100);
      got = obs(); exp = {1'b1, 1'b1, 32'h48}; total++;
      if (got !== exp) begin bad++; $display("FAIL train_back_to_wt: got=%h want=%h", got, exp); end
   endtask

   task automatic test_alias();
      update(32'h140, 32'h80, 1'b1, 1'b0);
      lookup(32'h100);
      got = obs(); exp = {1'b1, 1'b0, 32'h0}; total++;
      if (got !== exp) begin bad++; $display("FAIL alias_evicted: got=%h want=%h", got, exp); end
      lookup(32'h140);
      got = obs(); exp = {1'b1, 1'b1, 32'h80}; total++;
      if (got !== exp) begin bad++; $display("FAIL alias_new_owner: got=%h want=%h", got, exp); end
   endtask

   task automatic test_jump();
      update(32'h200, 32'h300, 1'b1, 1'b1);
      update(32'h200, 32'h0, 1'b0, 1'b0);
      lookup(32'h200);
      got = obs(); exp = {1'b1, 1'b1, 32'h300}; total++;
      if (got !== exp) begin bad++; $display("FAIL jump_st_then_nt: got=%h want=%h", got, exp); end
      update(32'h200, 32'h0, 1'b0, 1'b0);
      lookup(32'h200);
      got = obs(); exp = {1'b1, 1'b0, 32'h300}; total++;
      if (got !== exp) begin bad++; $display("FAIL jump_wnt: got=%h want=%h", got, exp); end
      update(32'h200, 32'h310, 1'b1, 1'b1);
      update(32'h200, 32'h320, 1'b1, 1'b0);
      update(32'h200, 32'h0, 1'b0, 1'b0);
      lookup(32'h200);
      got = obs(); exp = {1'b1, 1'b1, 32'h320}; total++;
      if (got !== exp) begin bad++; $display("FAIL jump_st_saturate: got=%h want=%h", got, exp); end
   endtask

   task automatic test_same_cycle();
      bp_if.i_fetch_en   = 1'b1;
      bp_if.i_pc         = 32'h180;
      bp_if.i_upd_en     = 1'b1;
      bp_if.i_upd_pc     = 32'h180;
      bp_if.i_upd_target = 32'h1C0;
      bp_if.i_upd_taken  = 1'b1;
      bp_if.i_upd_jump   = 1'b0;
      cyc();
      bp_if.i_upd_en = 1'b0;
      got = obs(); exp = {1'b1, 1'b0, 32'h0}; total++;
      if (got !== exp) begin bad++; $display("FAIL same_cycle_old_data: got=%h want=%h", got, exp); end
      cyc();
      bp_if.i_fetch_en = 1'b0;
      got = obs(); exp = {1'b1, 1'b1, 32'h1C0}; total++;
      if (got !== exp) begin bad++; $display("FAIL same_cycle_next_hit: got=%h want=%h", got, exp); end
   endtask

   task automatic test_stall_flush();
      lookup(32'h180);
      bp_if.i_stall      = 1'b1;
      bp_if.i_fetch_en   = 1'b1;
      bp_if.i_pc         = 32'h100;
      bp_if.i_upd_en     = 1'b1;
      bp_if.i_upd_pc     = 32'h304;
      bp_if.i_upd_target = 32'h500;
      bp_if.i_upd_taken  = 1'b1;
      bp_if.i_upd_jump   = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         bp_if.i_upd_en = 1'b0;
         got = obs(); exp = {1'b1, 1'b1, 32'h1C0}; total++;
         if (got !== exp) begin bad++; $display("FAIL stall_hold_%0d: got=%h want=%h", i, got, exp); end
      end
      bp_if.i_stall = 1'b0;
      bp_if.i_pc    = 32'h304;
      cyc();
      got = obs(); exp = {1'b1, 1'b1, 32'h500}; total++;
      if (got !== exp) begin bad++; $display("FAIL stall_update_commit: got=%h want=%h", got, exp); end
      bp_if.i_stall = 1'b1;
      bp_if.i_flush = 1'b1;
      cyc();
      total++;
      if (bp_if.o_pred_valid !== 1'b0) begin
         bad++; $display("FAIL flush_over_stall: got valid=%b want 0", bp_if.o_pred_valid);
      end
      bp_if.i_stall = 1'b0;
      bp_if.i_flush = 1'b0;
      cyc();
      got = obs(); exp = {1'b1, 1'b1, 32'h500}; total++;
      if (got !== exp) begin bad++; $display("FAIL after_flush_lookup: got=%h want=%h", got, exp); end
      bp_if.i_flush = 1'b1;
      cyc();
      bp_if.i_flush    = 1'b0;
      bp_if.i_fetch_en = 1'b0;
      total++;
      if (bp_if.o_pred_valid !== 1'b0) begin
         bad++; $display("FAIL flush_with_fetch: got valid=%b want 0", bp_if.o_pred_valid);
      end
   endtask

   task automatic test_reset_mid();
      bp_if.i_fetch_en = 1'b1;
      bp_if.i_pc       = 32'h304;
      cyc();
      got = obs(); exp = {1'b1, 1'b1, 32'h500}; total++;
      if (got !== exp) begin bad++; $display("FAIL pre_reset_hit: got=%h want=%h", got, exp); end
      #2;
      rst_n = 1'b0;
      bp_if.i_upd_en     = 1'b1;
      bp_if.i_upd_pc     = 32'h308;
      bp_if.i_upd_target = 32'h600;
      bp_if.i_upd_taken  = 1'b1;
      bp_if.i_upd_jump   = 1'b1;
      #1;
      got = obs(); exp = '0; total++;
      if (got !== exp) begin bad++; $display("FAIL async_reset_outputs: got=%h want=%h", got, exp); end
      cyc();
      got = obs(); total++;
      if (got !== exp) begin bad++; $display("FAIL reset_held_outputs: got=%h want=%h", got, exp); end
      #2;
      rst_n = 1'b1;
      bp_if.i_upd_en   = 1'b0;
      bp_if.i_fetch_en = 1'b0;
      lookup(32'h304);
      got = obs(); exp = {1'b1, 1'b0, 32'h0}; total++;
      if (got !== exp) begin bad++; $display("FAIL post_reset_miss_304: got=%h want=%h", got, exp); end
      lookup(32'h180);
      got = obs(); total++;
      if (got !== exp) begin bad++; $display("FAIL post_reset_miss_180: got=%h want=%h", got, exp); end
      lookup(32'h308);
      got = obs(); total++;
      if (got !== exp) begin bad++; $display("FAIL post_reset_no_update_308: got=%h want=%h", got, exp); end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_train();
      test_alias();
      test_jump();
      test_same_cycle();
      test_stall_flush();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
